// File: rtl/store_pkg.sv
// Shared constants and types for the store unit: funct3 encodings,
// completion error codes and the controller state encoding.
package store_pkg;

   localparam logic [2:0] F3_SB = 3'b000;
   localparam logic [2:0] F3_SH = 3'b001;
   localparam logic [2:0] F3_SW = 3'b010;

   localparam logic [1:0] ERR_NONE    = 2'b00;
   localparam logic [1:0] ERR_FUNC3   = 2'b01;
   localparam logic [1:0] ERR_ALIGN   = 2'b10;
   localparam logic [1:0] ERR_TIMEOUT = 2'b11;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      REQ  = 2'b01,
      RESP = 2'b10
   } state_t;

endpackage

// File: rtl/store_lane_align.sv
// Combinational lane steering for SB/SH/SW: byte enables, replicated
// write data and the reject flags.
// Optional macro MISALIGN_TRAP_EN: flags misaligned SH/SW so the unit can
// reject them. Without it the low address bits that do not select a lane
// are simply ignored.
module store_lane_align
   import store_pkg::*;
(
   input  logic [2:0]  func3,
   input  logic [1:0]  ea_lo,
   input  logic [31:0] rs2,
   output logic [3:0]  be,
   output logic [31:0] wdata,
   output logic        misaligned,
   output logic        bad_func3
);

   // decode store width into lane enables and replicated data
   always_comb begin
      be         = 4'b0000;
      wdata      = 32'h0000_0000;
      misaligned = 1'b0;
      bad_func3  = 1'b0;
      case (func3)
         F3_SB: begin
            be    = 4'b0001 << ea_lo;
            wdata = {4{rs2[7:0]}};
         end
         F3_SH: begin
            be    = ea_lo[1] ? 4'b1100 : 4'b0011;
            wdata = {2{rs2[15:0]}};
`ifdef MISALIGN_TRAP_EN
            misaligned = ea_lo[0];
`else
            misaligned = 1'b0;
`endif
         end
         F3_SW: begin
            be    = 4'b1111;
            wdata = rs2;
`ifdef MISALIGN_TRAP_EN
            misaligned = (ea_lo != 2'b00);
`else
            misaligned = 1'b0;
`endif
         end
         default: bad_func3 = 1'b1;
      endcase
   end

endmodule

// File: rtl/store_unit.sv
// Execution-stage store unit: one store in flight, req/ack to data memory,
// single-cycle done pulse with error code.
// Optional macro MISALIGN_TRAP_EN (see store_lane_align) enables rejection
// of misaligned SH/SW with ERR_ALIGN.
//
// state | meaning
// IDLE  | st_ready high, waiting for st_valid
// REQ   | mem_req held with stable addr/data/be until mem_ack or timeout
// RESP  | st_done pulse with st_err/st_err_code, then back to IDLE
module store_unit
   import store_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 16,
   parameter int unsigned ADDR_W         = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              st_valid,
   output logic              st_ready,
   input  logic [2:0]        func3,
   input  logic [31:0]       rs1,
   input  logic [31:0]       rs2,
   input  logic [31:0]       imm,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic [3:0]        mem_be,
   input  logic              mem_ack,
   output logic              st_done,
   output logic              st_err,
   output logic [1:0]        st_err_code
);

   localparam int unsigned CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] TO_LIM = CNT_W'(TIMEOUT_CYCLES);

   state_t             state_q, state_d;
   logic [31:0]        ea;
   logic [3:0]         al_be;
   logic [31:0]        al_wdata;
   logic               al_misaligned;
   logic               al_bad_func3;
   logic               accept;
   logic               reject;
   logic [CNT_W-1:0]   cnt_q;
   logic [CNT_W-1:0]   cnt_inc;
   logic               timeout_hit;
   logic [ADDR_W-1:0]  addr_q;
   logic [31:0]        wdata_q;
   logic [3:0]         be_q;
   logic [1:0]         err_q;

   assign ea          = rs1 + imm;
   assign accept      = st_valid && (state_q == IDLE);
   assign reject      = al_bad_func3 || al_misaligned;
   assign cnt_inc     = cnt_q + 1'b1;
   // ack has priority: timeout only counts when ack is absent this cycle
   assign timeout_hit = (TIMEOUT_CYCLES != 0) && !mem_ack && (cnt_inc == TO_LIM);

   store_lane_align u_align (
      .func3      (func3),
      .ea_lo      (ea[1:0]),
      .rs2        (rs2),
      .be         (al_be),
      .wdata      (al_wdata),
      .misaligned (al_misaligned),
      .bad_func3  (al_bad_func3)
   );

   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (accept) state_d = reject ? RESP : REQ;
         REQ:  if (mem_ack || timeout_hit) state_d = RESP;
         RESP: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // outputs decoded from state; be is masked so it is zero whenever no request
   always_comb begin
      st_ready    = (state_q == IDLE);
      mem_req     = (state_q == REQ);
      mem_be      = (state_q == REQ) ? be_q : 4'b0000;
      st_done     = (state_q == RESP);
      st_err_code = (state_q == RESP) ? err_q : ERR_NONE;
      st_err      = (state_q == RESP) && (err_q != ERR_NONE);
   end

   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;

   // operand capture at acceptance, timeout counting while waiting for ack
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_q  <= '0;
         wdata_q <= '0;
         be_q    <= '0;
         err_q   <= ERR_NONE;
         cnt_q   <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               cnt_q <= '0;
               if (accept) begin
                  addr_q  <= {ea[ADDR_W-1:2], 2'b00};
                  wdata_q <= al_wdata;
                  be_q    <= al_be;
                  if (al_bad_func3)       err_q <= ERR_FUNC3;
                  else if (al_misaligned) err_q <= ERR_ALIGN;
                  else                    err_q <= ERR_NONE;
               end
            end
            REQ: begin
               if (mem_ack) begin
                  cnt_q <= '0;
               end else begin
                  cnt_q <= cnt_inc;
                  if (timeout_hit) err_q <= ERR_TIMEOUT;
               end
            end
            default: cnt_q <= '0;
         endcase
      end
   end

endmodule

// File: tb/tb_store_unit.sv
// Directed bench for store_unit with a queue-based scoreboard: the stimulus
// pushes expected memory transactions and completions, a negedge monitor
// pops and compares them as the DUT presents them.
module tb_store_unit;
   import store_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        st_valid = 1'b0;
   logic        st_ready;
   logic [2:0]  func3 = 3'b000;
   logic [31:0] rs1 = '0, rs2 = '0, imm = '0;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_be;
   logic        mem_ack = 1'b0;
   logic        st_done;
   logic        st_err;
   logic [1:0]  st_err_code;

   typedef struct {
      logic [31:0] addr;
      logic [3:0]  be;
      logic [31:0] wd;
   } mem_exp_t;

   mem_exp_t    mem_q[$];
   logic [1:0]  done_q[$];
   mem_exp_t    cur;
   logic        req_prev = 1'b0;
   int          n_tests = 0;
   int          n_fail = 0;

   store_unit #(.TIMEOUT_CYCLES(16), .ADDR_W(32)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .st_valid    (st_valid),
      .st_ready    (st_ready),
      .func3       (func3),
      .rs1         (rs1),
      .rs2         (rs2),
      .imm         (imm),
      .mem_req     (mem_req),
      .mem_addr    (mem_addr),
      .mem_wdata   (mem_wdata),
      .mem_be      (mem_be),
      .mem_ack     (mem_ack),
      .st_done     (st_done),
      .st_err      (st_err),
      .st_err_code (st_err_code)
   );

   always #5 clk = ~clk;

   function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endfunction

   // monitor: compare memory requests and completions against the queues
   always @(negedge clk) begin
      mem_exp_t   e;
      logic [1:0] code;
      if (st_done) begin
         if (done_q.size() == 0) begin
            chk("unexpected_done", 32'(st_done), 32'd0);
         end else begin
            code = done_q.pop_front();
            chk("err_code", 32'(st_err_code), 32'(code));
            chk("err_flag", 32'(st_err), 32'(code != ERR_NONE));
         end
      end
      if (mem_req && !req_prev) begin
         if (mem_q.size() == 0) begin
            chk("unexpected_req", 32'(mem_req), 32'd0);
         end else begin
            e = mem_q.pop_front();
            cur = e;
            chk("mem_addr", mem_addr, e.addr);
            chk("mem_be", 32'(mem_be), 32'(e.be));
            chk("mem_wdata", mem_wdata, e.wd);
         end
      end else if (mem_req) begin
         chk("stable_addr", mem_addr, cur.addr);
         chk("stable_be", 32'(mem_be), 32'(cur.be));
         chk("stable_wdata", mem_wdata, cur.wd);
      end
      if (!mem_req) chk("be_idle_zero", 32'(mem_be), 32'd0);
      req_prev = mem_req;
   end

   task automatic run_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] im, input int ack_at, input logic exp_req,
                            input logic [31:0] e_addr, input logic [3:0] e_be,
                            input logic [31:0] e_wd, input logic [1:0] e_code,
                            input int e_lat, input int e_reqcyc, input string tag);
      int lat;
      int reqcyc;
      bit seen;
      @(negedge clk);
      chk({tag, "_ready"}, 32'(st_ready), 32'd1);
      if (exp_req) mem_q.push_back('{e_addr, e_be, e_wd});
      done_q.push_back(e_code);
      st_valid = 1'b1;
      func3 = f3;
      rs1 = a;
      rs2 = b;
      imm = im;
      @(posedge clk);
      #1 st_valid = 1'b0;
      lat = 0;
      reqcyc = 0;
      seen = 1'b0;
      for (int k = 1; k <= 40 && !seen; k++) begin
         @(negedge clk);
         if (mem_req) reqcyc++;
         if (st_done) begin
            seen = 1'b1;
            lat = k;
         end
         mem_ack = (k == ack_at);
      end
      mem_ack = 1'b0;
      chk({tag, "_latency"}, 32'(lat), 32'(e_lat));
      chk({tag, "_req_cycles"}, 32'(reqcyc), 32'(e_reqcyc));
   endtask

   initial begin
      #2 rst_n = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_ready", 32'(st_ready), 32'd1);
      chk("rst_req", 32'(mem_req), 32'd0);
      chk("rst_addr", mem_addr, 32'd0);
      chk("rst_wdata", mem_wdata, 32'd0);
      chk("rst_be", 32'(mem_be), 32'd0);
      chk("rst_done", 32'(st_done), 32'd0);
      chk("rst_err", 32'(st_err), 32'd0);
      chk("rst_code", 32'(st_err_code), 32'd0);
      rst_n = 1'b1;

      run_store(F3_SW, 32'h1000, 32'hDEADBEEF, 32'd4, 1, 1'b1,
                32'h1004, 4'b1111, 32'hDEADBEEF, ERR_NONE, 2, 1, "sw_basic");
      run_store(F3_SB, 32'h2000, 32'h0000_00A5, 32'd3, 4, 1'b1,
                32'h2000, 4'b1000, 32'hA5A5A5A5, ERR_NONE, 5, 4, "sb_lane3");
      run_store(F3_SB, 32'h6000, 32'h0000_003C, 32'd1, 1, 1'b1,
                32'h6000, 4'b0010, 32'h3C3C3C3C, ERR_NONE, 2, 1, "sb_lane1");
      run_store(F3_SH, 32'hFFFF_FFFF, 32'hCAFE5678, 32'd3, 2, 1'b1,
                32'h0000_0000, 4'b1100, 32'h56785678, ERR_NONE, 3, 2, "sh_wrap");
`ifdef MISALIGN_TRAP_EN
      run_store(F3_SH, 32'h3000, 32'h1234ABCD, 32'd1, 2, 1'b0,
                32'h0, 4'b0, 32'h0, ERR_ALIGN, 1, 0, "sh_mis");
      run_store(F3_SW, 32'h7000, 32'h55AA55AA, 32'd2, 1, 1'b0,
                32'h0, 4'b0, 32'h0, ERR_ALIGN, 1, 0, "sw_mis");
`else
      run_store(F3_SH, 32'h3000, 32'h1234ABCD, 32'd1, 2, 1'b1,
                32'h3000, 4'b0011, 32'hABCDABCD, ERR_NONE, 3, 2, "sh_mis");
      run_store(F3_SW, 32'h7000, 32'h55AA55AA, 32'd2, 1, 1'b1,
                32'h7000, 4'b1111, 32'h55AA55AA, ERR_NONE, 2, 1, "sw_mis");
`endif
      run_store(3'b011, 32'h1000, 32'h1, 32'd0, 0, 1'b0,
                32'h0, 4'b0, 32'h0, ERR_FUNC3, 1, 0, "bad_f3");
      run_store(F3_SW, 32'h4000, 32'h11223344, 32'h10, 0, 1'b1,
                32'h4010, 4'b1111, 32'h11223344, ERR_TIMEOUT, 17, 16, "timeout");
      run_store(F3_SW, 32'h4000, 32'h11223344, 32'h10, 16, 1'b1,
                32'h4010, 4'b1111, 32'h11223344, ERR_NONE, 17, 16, "ack_at_limit");
      run_store(F3_SB, 32'hFFFF_FFFC, 32'h0000_0077, 32'd8, 1, 1'b1,
                32'h0000_0004, 4'b0001, 32'h77777777, ERR_NONE, 2, 1, "sb_wrap");

      // reset while waiting in REQ: store is abandoned without completion
      @(negedge clk);
      mem_q.push_back('{32'h8000, 4'b1111, 32'h0BADF00D});
      st_valid = 1'b1;
      func3 = F3_SW;
      rs1 = 32'h8000;
      imm = 32'h0;
      rs2 = 32'h0BADF00D;
      @(posedge clk);
      #1 st_valid = 1'b0;
      repeat (3) @(negedge clk);
      chk("mid_req_active", 32'(mem_req), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_req", 32'(mem_req), 32'd0);
      chk("mid_rst_be", 32'(mem_be), 32'd0);
      chk("mid_rst_done", 32'(st_done), 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_rst_ready", 32'(st_ready), 32'd1);
      run_store(F3_SW, 32'h9000, 32'h01020304, 32'hFFFF_FFFC, 1, 1'b1,
                32'h8FFC, 4'b1111, 32'h01020304, ERR_NONE, 2, 1, "sw_after_rst");

      repeat (2) @(negedge clk);
      chk("mem_q_empty", 32'(mem_q.size()), 32'd0);
      chk("done_q_empty", 32'(done_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/store_unit.md
Name: store_unit

Overview:
Execution-stage store unit, the write-side counterpart of the load path. It accepts one store per handshake (SB/SH/SW selected by funct3) and computes the effective address rs1+imm. It generates byte enables and lane-replicated write data, then drives a request/acknowledge transaction to data memory. It reports completion or an error to the pipeline, and only one store is in flight at a time.

Parameters:
TIMEOUT_CYCLES, 16, maximum cycles in REQ waiting for mem_ack before aborting; 0 disables the timeout.
ADDR_W, 32, effective address width.

Ports:
clk  input  1  clock, rising edge.
rst_n  input  1  reset, asynchronous, active-low.
st_valid  input  1  store request valid from the execute stage.
st_ready  output  1  unit can accept a request (high only in IDLE).
func3  input  3  store type: 000 SB, 001 SH, 010 SW.
rs1  input  32  base register value.
rs2  input  32  store data register value.
imm  input  32  sign-extended S-type immediate.
mem_req  output  1  memory write request.
mem_addr  output  ADDR_W  byte address, word-aligned (addr[1:0] forced to 00).
mem_wdata  output  32  lane-replicated write data.
mem_be  output  4  byte enables.
mem_ack  input  1  memory accepted the write.
st_done  output  1  one-cycle completion pulse.
st_err  output  1  valid with st_done; store failed.
st_err_code  output  2  00 none, 01 bad funct3, 10 misaligned, 11 timeout.

Behaviour:
- Reset (async, rst_n=0): state IDLE, st_ready=1, mem_req=0, mem_addr/mem_wdata=0, mem_be=0, st_done=0, st_err=0, st_err_code=00, timeout counter=0. Reset mid-transaction abandons the store silently and sends no st_done.
- Address: ea = rs1+imm, 32-bit wrap-around with no overflow detection. mem_addr = {ea[31:2],2'b00}.
- Lane alignment:
  - SB: be = 0001<<ea[1:0]; wdata = {4{rs2[7:0]}}.
  - SH: be = ea[1] ? 1100 : 0011; wdata = {2{rs2[15:0]}}.
  - SW: be = 1111; wdata = rs2.
- FSM states: IDLE, REQ, RESP.
- IDLE: st_ready=1. Acceptance is st_valid&&st_ready in cycle N. Operands are registered at acceptance.
  - funct3 not SB/SH/SW: go to RESP with err 01; no mem_req.
  - Misaligned (see feature): go to RESP with err 10; no mem_req.
  - Otherwise go to REQ. mem_req=1 from cycle N+1.
- REQ: mem_req, mem_addr, mem_wdata, mem_be stay stable until mem_ack is sampled high. On ack: mem_req drops next cycle, go to RESP with err 00.
  - Counter increments each REQ cycle without ack.
  - If TIMEOUT_CYCLES!=0 and the counter reaches TIMEOUT_CYCLES: drop mem_req, go to RESP with err 11.
  - If ack and timeout occur in the same cycle, ack wins.
- RESP: st_done=1 for exactly one cycle, with st_err=(code!=00). Then return to IDLE; the counter clears.
- Latency:
  - Ack in the first REQ cycle gives st_done at N+2.
  - Error rejects give st_done at N+1.
  - Next acceptance is possible in the cycle after st_done (st_ready=0 in REQ/RESP).
- mem_ack outside REQ is ignored.
- mem_be=0000 whenever mem_req=0.

Optional Feature:
MISALIGN_TRAP_EN
- Defined: SH with ea[0]=1, or SW with ea[1:0]!=00, is rejected with err 10 and never reaches memory.
- Undefined: no misalignment check. Offending low address bits are ignored for lane selection: SH uses ea[1] only, and SW always uses be=1111. The store proceeds normally.

Decomposition:
- Package store_pkg holds:
  - funct3 constants (F3_SB, F3_SH, F3_SW).
  - Error-code constants (ERR_NONE, ERR_FUNC3, ERR_ALIGN, ERR_TIMEOUT).
  - The state typedef (IDLE/REQ/RESP).
- Sub-module store_lane_align is purely combinational: inputs func3, ea[1:0], rs2; outputs be, wdata, misaligned, bad_func3. The FSM and timeout counter stay in store_unit.

Test Plan:
- SW, rs1=0x1000, imm=4, rs2=0xDEADBEEF, ack on first REQ cycle -> mem_addr=0x1004, be=1111, wdata=0xDEADBEEF, st_done at N+2, st_err=0.
- SB, rs1=0x2000, imm=3, rs2=0x000000A5, ack after 3 cycles -> mem_addr=0x2000, be=1000, wdata=0xA5A5A5A5, request stable for 4 cycles, then st_done.
- SH, ea=0x3001 -> with MISALIGN_TRAP_EN: no mem_req, st_done at N+1, err=10. Without it: be=0011, wdata={2{rs2[15:0]}}, completes normally.
- func3=011 with st_valid -> no mem_req, st_done at N+1, st_err=1, code=01.
- mem_ack held low, TIMEOUT_CYCLES=16 -> mem_req high 16 cycles then low, st_done with code=11. Repeat with ack on cycle 16 -> code=00.
- rst_n asserted while in REQ -> mem_req=0 immediately (async), no st_done; st_ready=1 after release, and a new SW completes normally.
